// File: rtl/rr_range_arb_pkg.sv
// Shared types and defaults for the round-robin range arbiter.
// RANGE_ARB_TIMEOUT_EN (see rr_range_arbiter) sizes its counter with cnt_width().
package rr_range_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StGrant,
        StBusy
    } arb_state_e;

    localparam int unsigned N_DEFAULT           = 32;
    localparam int unsigned IDXW_DEFAULT        = 5;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

    // Counter is at least 8 bits, wider if the timeout needs it.
    function automatic int unsigned cnt_width(input int unsigned max_cyc);
        int unsigned w;
        w = $clog2(max_cyc + 32'd1);
        return (w > 32'd8) ? w : 32'd8;
    endfunction

endpackage

// File: rtl/range_mask_gen.sv
// Thermometer range decode: mask_o[i] is set for every index at or above ptr_i.
module range_mask_gen
    import rr_range_arb_pkg::*;
#(
    parameter int unsigned N    = N_DEFAULT,
    parameter int unsigned IDXW = IDXW_DEFAULT
) (
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    mask_o
);

    always_comb begin
        mask_o = '0;
        for (int unsigned i = 0; i < N; i++) begin
            mask_o[i] = (i >= 32'(ptr_i));
        end
    end

endmodule

// File: rtl/rr_range_arbiter.sv
// Round-robin arbiter granting one shared slot, held until release or abandon.
// Define RANGE_ARB_TIMEOUT_EN to add a forced release after TIMEOUT_CYC busy cycles.
module rr_range_arbiter
    import rr_range_arb_pkg::*;
#(
    parameter int unsigned N           = N_DEFAULT,
    parameter int unsigned IDXW        = IDXW_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            rel,
    output logic [N-1:0]    gnt,
    output logic [IDXW-1:0] gnt_idx,
    output logic            gnt_vld,
    output logic            busy,
    output logic            timeout
);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_vld_q, gnt_vld_d;
    logic [N-1:0]    mask, masked;
    logic [IDXW-1:0] win_idx;
    logic            expire;
    logic            exit_grant;

    range_mask_gen #(
        .N    (N),
        .IDXW (IDXW)
    ) u_range_mask (
        .ptr_i  (ptr_q),
        .mask_o (mask)
    );

    assign masked = req & mask;

    // Lowest requester at or above the pointer, else wrap to the lowest requester.
    always_comb begin
        win_idx = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) win_idx = IDXW'(i);
        end
        if (|masked) begin
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (masked[i]) win_idx = IDXW'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_vld_d  = gnt_vld_q;
        exit_grant = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d          = StGrant;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_idx_d        = win_idx;
                    gnt_vld_d        = 1'b1;
                end
            end
            StGrant: begin
                if (rel) exit_grant = 1'b1;
                else     state_d    = StBusy;
            end
            StBusy: begin
                if (rel || !req[gnt_idx_q] || expire) exit_grant = 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // gnt_idx deliberately keeps the last owner after release.
        if (exit_grant) begin
            state_d   = StIdle;
            gnt_d     = '0;
            gnt_vld_d = 1'b0;
            ptr_d     = gnt_idx_q + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

`ifdef RANGE_ARB_TIMEOUT_EN
    localparam int unsigned       CntW    = cnt_width(TIMEOUT_CYC);
    localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT_CYC - 32'd1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;

    // Expiry on the TIMEOUT_CYC-th busy cycle; a coincident rel or abandon wins.
    assign expire = (state_q == StBusy) && (cnt_q == CntLast);

    always_comb begin
        cnt_d     = '0;
        timeout_d = 1'b0;
        if (state_q == StBusy) begin
            cnt_d     = cnt_q + CntW'(1);
            timeout_d = expire && !rel && req[gnt_idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
    assign expire             = 1'b0;
    assign timeout            = 1'b0;
`endif

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_rr_range_arbiter.sv
// Directed bench for rr_range_arbiter: pointer order, wrap, abandon, async reset, timeout.
module tb_rr_range_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] req;
    logic        rel;
    logic [31:0] gnt;
    logic [4:0]  gnt_idx;
    logic        gnt_vld;
    logic        busy;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    rr_range_arbiter #(
        .N           (32),
        .IDXW        (5),
        .TIMEOUT_CYC (10)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 32'hFFFF_FFFF;
        rel   = 1'b0;

        // Reset with all requests asserted
        step();
        step();
        chk("rst_gnt", gnt, 32'h0);
        chk("rst_idx", 32'(gnt_idx), 32'd0);
        chk("rst_vld", 32'(gnt_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_gnt", gnt, 32'h1);
        chk("first_idx", 32'(gnt_idx), 32'd0);
        chk("first_vld", 32'(gnt_vld), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        step();
        chk("busy_hold_gnt", gnt, 32'h1);
        rel = 1'b1;
        step();
        chk("rel_gnt", gnt, 32'h0);
        chk("rel_vld", 32'(gnt_vld), 32'd0);
        chk("rel_idx_kept", 32'(gnt_idx), 32'd0);
        rel = 1'b0;

        // Pointer order from ptr=0: 0, 4, 31, 0
        rst_n = 1'b0;
        req   = 32'h8000_0011;
        #2;
        rst_n = 1'b1;
        step();
        chk("ord0_idx", 32'(gnt_idx), 32'd0);
        step();
        rel = 1'b1;
        step();
        chk("ord_gap_gnt", gnt, 32'h0);
        chk("ord_gap_busy", 32'(busy), 32'd0);
        rel = 1'b0;
        step();
        chk("ord4_gnt", gnt, 32'h0000_0010);
        chk("ord4_idx", 32'(gnt_idx), 32'd4);
        step();
        rel = 1'b1;
        step();
        chk("ord4_rel_gnt", gnt, 32'h0);
        rel = 1'b0;
        step();
        chk("ord31_gnt", gnt, 32'h8000_0000);
        chk("ord31_idx", 32'(gnt_idx), 32'd31);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        step();
        chk("ord_wrap0_idx", 32'(gnt_idx), 32'd0);

        // rel during GRANT is honoured
        rel = 1'b1;
        step();
        chk("grant_rel_gnt", gnt, 32'h0);
        chk("grant_rel_busy", 32'(busy), 32'd0);
        rel = 1'b0;

        // Wrap: owner 31 releases, ptr=0
        req = 32'h8000_0000;
        step();
        chk("wrap_own31", 32'(gnt_idx), 32'd31);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 32'h0000_0004;
        step();
        chk("wrap_idx2", 32'(gnt_idx), 32'd2);
        chk("wrap_gnt2", gnt, 32'h0000_0004);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 32'h0000_0010;
        step();
        chk("own4_idx", 32'(gnt_idx), 32'd4);
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 32'h0000_0009;
        step();
        chk("empty_mask_idx", 32'(gnt_idx), 32'd0);
        chk("empty_mask_gnt", gnt, 32'h1);

        // Abandon by owner 7
        step();
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 32'h0000_0080;
        step();
        chk("own7_idx", 32'(gnt_idx), 32'd7);
        step();
        req = 32'h0;
        step();
        chk("abandon_gnt", gnt, 32'h0);
        chk("abandon_vld", 32'(gnt_vld), 32'd0);
        chk("abandon_idx", 32'(gnt_idx), 32'd7);
        rel = 1'b1;
        step();
        chk("idle_rel_gnt", gnt, 32'h0);
        chk("idle_rel_busy", 32'(busy), 32'd0);
        rel = 1'b0;
        req = 32'h0000_0180;
        step();
        chk("abandon_ptr8", 32'(gnt_idx), 32'd8);
        step();
        req = 32'h0000_0108;
        step();
        chk("other_req_ignored", gnt, 32'h0000_0100);

        // Asynchronous reset while owner 12 is busy
        rel = 1'b1;
        step();
        rel = 1'b0;
        req = 32'h0000_1000;
        step();
        chk("own12_idx", 32'(gnt_idx), 32'd12);
        step();
        chk("own12_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_gnt", gnt, 32'h0);
        chk("async_rst_vld", 32'(gnt_vld), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_idx", 32'(gnt_idx), 32'd0);
        req = 32'h8000_0001;
        #1;
        rst_n = 1'b1;
        step();
        chk("async_rst_ptr0", 32'(gnt_idx), 32'd0);

`ifdef RANGE_ARB_TIMEOUT_EN
        // Owner 0 holds with no rel: forced release after 10 busy cycles
        repeat (10) step();
        chk("to_hold_gnt", gnt, 32'h1);
        chk("to_hold_pulse", 32'(timeout), 32'd0);
        step();
        chk("to_fire_gnt", gnt, 32'h0);
        chk("to_fire_pulse", 32'(timeout), 32'd1);
        step();
        chk("to_pulse_end", 32'(timeout), 32'd0);
        chk("to_ptr_adv", 32'(gnt_idx), 32'd31);
        repeat (10) step();
        rel = 1'b1;
        step();
        chk("to_rel_gnt", gnt, 32'h0);
        chk("to_rel_pulse", 32'(timeout), 32'd0);
        rel = 1'b0;
`else
        // Without the timeout feature the grant is held indefinitely
        repeat (11) step();
        chk("nto_hold_gnt", gnt, 32'h1);
        chk("nto_pulse", 32'(timeout), 32'd0);
        rel = 1'b1;
        step();
        chk("nto_rel_gnt", gnt, 32'h0);
        rel = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_range_arbiter.md
Name: rr_range_arbiter

Overview:
- Round-robin arbiter sharing one 32-slot resource among N requesters.
- A 5-bit priority pointer drives a thermometer range mask (bit i set when i >= ptr).
- The mask picks the next winner at or above the pointer, wrapping to the lowest requester otherwise.
- Sits between requester agents and the shared datapath; each grant is held until the owner releases it.

Parameters:
- N, 32, number of requesters; power of two, 2..32.
- IDXW, 5, index width = log2(N).
- TIMEOUT_CYC, 255, max BUSY cycles before forced release; used only with the optional feature.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N  request vector, level-sensitive.
- rel  input  1  release pulse from the current owner.
- gnt  output  N  one-hot grant, registered.
- gnt_idx  output  IDXW  binary index of the current owner, registered.
- gnt_vld  output  1  high while a grant is held.
- busy  output  1  high in GRANT or BUSY.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state=IDLE, ptr=0.
  - gnt=0, gnt_idx=0, gnt_vld=0, busy=0, timeout=0.
- States: IDLE, GRANT, BUSY.
- IDLE:
  - When req!=0 at edge k, choose winner w and go to GRANT.
  - gnt[w]=1, gnt_idx=w, gnt_vld=1 are visible after edge k. Latency from req to gnt is 1 cycle.
  - req==0 stays in IDLE with outputs 0.
- Winner selection (combinational):
  - mask = range_mask(ptr), with mask[i]=(i>=ptr).
  - masked = req & mask.
  - w = lowest set bit of masked if masked!=0, else lowest set bit of req.
- GRANT:
  - Lasts one cycle, then goes to BUSY unconditionally. Grant outputs are held.
  - rel during GRANT is honoured: go to IDLE instead.
- BUSY:
  - Hold gnt, gnt_idx, gnt_vld.
  - Exit to IDLE when rel=1 or req[gnt_idx]=0 (abandon).
  - On exit: clear gnt/gnt_vld, set ptr=(gnt_idx+1) mod N, wrapping 31->0 for N=32.
  - gnt_idx keeps its last value after exit.
- Back-to-back grants have exactly one IDLE cycle between them. Arbitration uses the updated ptr.
- rel in IDLE is ignored.
- Requests arriving or dropping in GRANT/BUSY, other than the owner's, have no effect until IDLE.
- Reset mid-grant: immediate return to reset values; ptr returns to 0.
- busy = (state!=IDLE). gnt is always one-hot or zero.

Optional Feature:
- Macro: RANGE_ARB_TIMEOUT_EN.
- Enabled:
  - An 8-bit (or wider) counter clears on entry to GRANT and increments each BUSY cycle.
  - When it reaches TIMEOUT_CYC with no rel, force exit as a normal release (ptr advances) and pulse timeout=1 for one cycle, coincident with gnt clearing.
  - rel on the same cycle as expiry counts as a normal release; no timeout pulse.
- Disabled: no counter; the timeout port exists and is tied 0.

Decomposition:
- Package rr_range_arb_pkg:
  - state enum {IDLE, GRANT, BUSY}.
  - N_DEFAULT=32, IDXW_DEFAULT=5.
  - TIMEOUT_CYC_DEFAULT=255.
- Sub-module range_mask_gen:
  - Combinational IDXW->N thermometer mask, mask[i]=(i>=ptr).
  - Reused by other range-decode users.
- Priority-find and one-hot encode stay inline.

Test Plan:
- Reset with req=32'hFFFF_FFFF held: all outputs 0 during reset. First edge after deassert gives gnt=1<<0, gnt_idx=0, then state=BUSY.
- Pointer order: ptr=0, req=32'h8000_0011. rel after each grant gives winners 0, 4, 31, then 0 again. There is exactly one idle cycle between grants.
- Wrap: owner 31 releases, so ptr=0. With req=32'h0000_0004, gnt_idx=2. With ptr=5 and req=32'h0000_0009, the masked set is empty, so the winner is 0.
- Abandon: owner 7 drops req[7] with no rel. gnt clears next edge and ptr=8. rel pulsed in IDLE causes no change.
- Reset mid-grant: assert rst_n=0 asynchronously during BUSY with gnt_idx=12. gnt goes to 0 immediately without a clock edge, and ptr=0 after release.
- With RANGE_ARB_TIMEOUT_EN and TIMEOUT_CYC=10: owner holds with no rel, so a forced release occurs with timeout pulsed 1 cycle and ptr advanced. A repeat with rel on the expiry cycle gives timeout=0.
